proc_core_8bit: RTL and testbench
=================================

# proc_core_8bit

Multi-cycle 8-bit processor core that produces the program counter and four general-purpose registers shown on the board's seven-segment/LED display. Sits directly upstream of the display controller. Its `PC` and `R0`..`R3` outputs connect straight to the display inputs. It fetches 8-bit instructions from an external synchronous instruction ROM and executes one instruction every two clock cycles while `run` is high.

## Interface
- `PC_RESET`, default 8'h00: PC value after reset.
- `clk`  input  1  system clock; all state changes on the rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `run`  input  1  level enable; execution proceeds only while high (already synchronised and debounced upstream).
- `instr_data`  input  8  ROM read data; valid one cycle after `instr_addr` is presented.
- `instr_addr`  output  8  ROM address; always equals `PC`.
- `PC`  output  8  program counter, to the display.
- `R0`, `R1`, `R2`, `R3`  output  8 each  register file contents, to the display.
- `halted`  output  1  high once a HALT instruction has executed.

## Operation
- On reset:
  - `PC = PC_RESET`.
  - `R0`..`R3 = 0`.
  - `halted = 0`.
  - FSM enters FETCH.
- FSM states:
  - FETCH: `instr_addr = PC` is presented to the ROM. If `run = 1`, go to EXEC; otherwise stay in FETCH.
  - EXEC: decode and execute `instr_data`, update registers and PC, then go to FETCH. HALT instead goes to the HALT state.
  - HALT: terminal state. `halted = 1`; PC and registers are frozen. Only `rst_n` leaves this state.
- `run` is sampled only in FETCH. Once EXEC is entered, it always completes, even if `run` drops.
- Instruction encoding (`i = instr_data`):
  - `i[7:6]=00`, ALU: `Rd = Rd op Rs`.
    - `rd = i[3:2]`, `rs = i[1:0]`.
    - `i[5:4]` selects the op: 00 ADD, 01 SUB (`Rd - Rs`), 10 AND, 11 OR.
    - `PC += 1`.
  - `i[7:6]=01`, LDI: `R[i[5:4]] = {4'b0, i[3:0]}`; `PC += 1`.
  - `i[7:6]=10`, BNZ:
    - If `R[i[5:4]] != 0`, `PC = PC + sext(i[3:0])`, where the offset is 4-bit two's complement, -8..+7, relative to the branch's own address.
    - Otherwise `PC += 1`.
    - Offset 0 with a nonzero register is a legal self-loop.
  - `i[7:6]=11`:
    - `i[5:4]=00`: HALT. PC is not incremented.
    - `i[5:4]=01`: INC `R[i[3:2]]`.
    - `i[5:4]=10`: DEC `R[i[3:2]]`.
    - `i[5:4]=11`: NOP.
    - INC, DEC and NOP all do `PC += 1`.
- Arithmetic rules:
  - All arithmetic is 8-bit modulo 256. There are no flags and no exceptions.
  - PC wraps 8'hFF → 8'h00 on increment and on branch.
  - ALU with `rd == rs` uses the pre-instruction value for both operands (e.g. SUB R1,R1 gives 0).
- At most one register is written per instruction.

## Timing
- Each instruction takes 2 cycles (FETCH + EXEC) when `run` is held high.
- Register and PC updates become visible on the outputs on the clock edge that ends EXEC. All outputs are registered.
- The ROM is synchronous with 1-cycle read latency. `instr_data` is consumed only in EXEC.
- `halted` asserts on the edge that ends the HALT instruction's EXEC cycle.
- Asynchronous reset in any state, including mid-EXEC:
  - All outputs go to their reset values immediately, without waiting for a clock edge.
  - The partially executed instruction has no effect.
  - The first FETCH occurs on the first rising edge after `rst_n` deasserts.

## Test plan
- **Reset:** assert `rst_n = 0` mid-EXEC of an `INC R0` → `PC = 00`, `R0..R3 = 00`, `halted = 0` with no clock edge. After release with `run = 1`, `instr_addr = 00` in the first FETCH.
- **Basic program:** ROM = {`LDI R0,5`; `LDI R1,3`; `ADD R0,R1`; `SUB R1,R1`; HALT}, `run = 1`.
  - Expect `R0 = 08`, `R1 = 00`, `PC = 04`, `halted = 1`.
  - `halted` rises exactly 10 cycles after the first FETCH.
  - PC and registers stay unchanged for 20 further cycles.
- **Branch loop:** {`LDI R2,3`; `DEC R2`; `BNZ R2,-1`; HALT}.
  - PC sequence is 00,01,02,01,02,01,02,03.
  - Final `R2 = 00`, `PC = 03`, `halted = 1`.
- **Run gating:** drop `run` during FETCH at PC = 01 for 7 cycles → PC and registers hold and `instr_addr` stays 01. Drop `run` during EXEC → that instruction completes and the core then stalls in FETCH.
- **Wrap-around:**
  - `PC_RESET = 8'hFF` with a NOP at FF → PC goes to 00.
  - `LDI R3,0` then `DEC R3` → `R3 = FF`.
  - `LDI R0,15`; `ADD R0,R0` ×4 → `R0 = F0`, then one more `ADD R0,R0` → `R0 = E0` (modulo 256).
- **Logic ops and aliasing:** `R1 = 0C`, `R2 = 0A`.
  - `AND R1,R2` → `R1 = 08`.
  - `OR R2,R1` → `R2 = 0A`.
  - `ADD R2,R2` → `R2 = 14`.
  - `BNZ R3,+2` with `R3 = 0` → `PC += 1`.

Source files
------------

// File: rtl/proc_core_8bit.sv
// Two-cycle-per-instruction 8-bit core driving the PC / R0..R3 display inputs.
// Instructions come from an external synchronous ROM with one cycle of read latency.
//
// state  | meaning
// -------+---------------------------------------------------------------
// S_FETCH| PC on instr_addr; wait here until run is high
// S_EXEC | decode instr_data, write at most one register, update PC
// S_HALT | terminal; PC and registers frozen until rst_n
module proc_core_8bit #(
   parameter logic [7:0] PC_RESET = 8'h00
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       run,
   input  logic [7:0] instr_data,
   output logic [7:0] instr_addr,
   output logic [7:0] PC,
   output logic [7:0] R0,
   output logic [7:0] R1,
   output logic [7:0] R2,
   output logic [7:0] R3,
   output logic       halted
);

   typedef enum logic [1:0] {
      S_FETCH = 2'd0,
      S_EXEC  = 2'd1,
      S_HALT  = 2'd2
   } state_t;

   state_t     state;
   logic [7:0] pc_q;
   logic [7:0] regs [4];
   logic       halted_q;

   logic [1:0] rd_sel;
   logic [1:0] rs_sel;
   logic [1:0] rn_sel;
   logic [7:0] op_a;
   logic [7:0] op_b;
   logic [7:0] alu_res;
   logic [7:0] rn_val;
   logic [7:0] br_off;
   logic [7:0] pc_inc;
   logic [7:0] pc_br;

   // Both ALU operands are read before the write, so rd == rs sees the old value.
   always_comb begin
      rd_sel = instr_data[3:2];
      rs_sel = instr_data[1:0];
      rn_sel = instr_data[5:4];
      op_a   = regs[rd_sel];
      op_b   = regs[rs_sel];
      rn_val = regs[rn_sel];
      br_off = {{4{instr_data[3]}}, instr_data[3:0]};
      pc_inc = pc_q + 8'd1;
      pc_br  = pc_q + br_off;
      alu_res = '0;
      case (instr_data[5:4])
         2'b00:   alu_res = op_a + op_b;
         2'b01:   alu_res = op_a - op_b;
         2'b10:   alu_res = op_a & op_b;
         default: alu_res = op_a | op_b;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= S_FETCH;
         pc_q     <= PC_RESET;
         halted_q <= 1'b0;
         for (int i = 0; i < 4; i++) regs[i] <= '0;
      end else begin
         case (state)
            S_FETCH: begin
               if (run) state <= S_EXEC;
            end
            S_EXEC: begin
               state <= S_FETCH;
               pc_q  <= pc_inc;
               case (instr_data[7:6])
                  2'b00: regs[rd_sel] <= alu_res;
                  2'b01: regs[rn_sel] <= {4'b0000, instr_data[3:0]};
                  2'b10: if (rn_val != 8'h00) pc_q <= pc_br;
                  default: begin
                     case (instr_data[5:4])
                        2'b00: begin
                           state    <= S_HALT;
                           halted_q <= 1'b1;
                           pc_q     <= pc_q;
                        end
                        2'b01:   regs[rd_sel] <= op_a + 8'd1;
                        2'b10:   regs[rd_sel] <= op_a - 8'd1;
                        default: ;
                     endcase
                  end
               endcase
            end
            S_HALT:  state <= S_HALT;
            default: state <= S_FETCH;
         endcase
      end
   end

   assign instr_addr = pc_q;
   assign PC         = pc_q;
   assign R0         = regs[0];
   assign R1         = regs[1];
   assign R2         = regs[2];
   assign R3         = regs[3];
   assign halted     = halted_q;

endmodule

// File: tb/tb_proc_core_8bit.sv
// Directed programs for proc_core_8bit; expected snapshots are queued and a
// monitor process compares them against the core outputs.
`timescale 1ns/1ps
module tb_proc_core_8bit;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       run = 1'b0;
   logic       run_b = 1'b0;
   logic [7:0] instr_data, instr_data_b;
   logic [7:0] instr_addr, pc, r0, r1, r2, r3;
   logic       halted;
   logic [7:0] instr_addr_b, pc_b, r0_b, r1_b, r2_b, r3_b;
   logic       halted_b;
   logic [7:0] rom [256];

   int total = 0;
   int bad = 0;

   typedef struct {
      string      name;
      bit         on_b;
      logic [7:0] pc;
      logic [7:0] r0, r1, r2, r3;
      logic       h;
   } exp_t;
   exp_t exp_q[$];

   always #5 clk = ~clk;

   proc_core_8bit #(.PC_RESET(8'h00)) dut (
      .clk(clk), .rst_n(rst_n), .run(run), .instr_data(instr_data),
      .instr_addr(instr_addr), .PC(pc), .R0(r0), .R1(r1), .R2(r2), .R3(r3),
      .halted(halted));

   proc_core_8bit #(.PC_RESET(8'hFF)) dut_b (
      .clk(clk), .rst_n(rst_n), .run(run_b), .instr_data(instr_data_b),
      .instr_addr(instr_addr_b), .PC(pc_b), .R0(r0_b), .R1(r1_b), .R2(r2_b), .R3(r3_b),
      .halted(halted_b));

   always @(posedge clk) begin
      instr_data   <= rom[instr_addr];
      instr_data_b <= rom[instr_addr_b];
   end

   // Monitor: compares each queued snapshot against the live outputs.
   initial begin
      exp_t e;
      forever begin
         wait (exp_q.size() != 0);
         e = exp_q.pop_front();
         total++;
         if (e.on_b) begin
            if (pc_b !== e.pc || instr_addr_b !== e.pc) begin
               bad++;
               $display("FAIL %s: got pc=%h addr=%h, want pc=%h", e.name, pc_b, instr_addr_b, e.pc);
            end
         end else if (pc !== e.pc || instr_addr !== e.pc || r0 !== e.r0 || r1 !== e.r1 ||
                      r2 !== e.r2 || r3 !== e.r3 || halted !== e.h) begin
            bad++;
            $display("FAIL %s: got pc=%h addr=%h r=%h,%h,%h,%h h=%b, want pc=%h r=%h,%h,%h,%h h=%b",
                     e.name, pc, instr_addr, r0, r1, r2, r3, halted,
                     e.pc, e.r0, e.r1, e.r2, e.r3, e.h);
         end
      end
   end

   task automatic expect_st(input string name, input logic [7:0] p, input logic [7:0] a,
                            input logic [7:0] b, input logic [7:0] c, input logic [7:0] d,
                            input logic h);
      exp_t e;
      e.name = name; e.on_b = 1'b0; e.pc = p;
      e.r0 = a; e.r1 = b; e.r2 = c; e.r3 = d; e.h = h;
      exp_q.push_back(e);
      #0;
   endtask

   task automatic expect_b(input string name, input logic [7:0] p);
      exp_t e;
      e.name = name; e.on_b = 1'b1; e.pc = p;
      e.r0 = '0; e.r1 = '0; e.r2 = '0; e.r3 = '0; e.h = 1'b0;
      exp_q.push_back(e);
      #0;
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Load program (remaining words HALT), reset, release on a falling edge.
   task automatic load_reset(input logic [7:0] prog [$], input logic run_v);
      @(negedge clk);
      rst_n = 1'b0;
      run   = 1'b0;
      run_b = 1'b0;
      for (int i = 0; i < 256; i++) rom[i] = 8'hC0;
      for (int i = 0; i < prog.size(); i++) rom[i] = prog[i];
      @(negedge clk);
      rst_n = 1'b1;
      run   = run_v;
   endtask

   initial begin
      logic [7:0] p [$];
      logic [7:0] br_seq [8];
      int n;

      // Basic program
      p = '{8'h45, 8'h53, 8'h01, 8'h15, 8'hC0};
      load_reset(p, 1'b1);
      expect_st("reset_state", 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
      n = 0;
      for (int i = 1; i <= 40; i++) begin
         cyc(1);
         if (halted === 1'b1) begin n = i; break; end
      end
      total++;
      if (n != 10) begin
         bad++;
         $display("FAIL halt_latency: got %0d cycles, want 10", n);
      end
      expect_st("basic_final", 8'h04, 8'h08, 8'h00, 8'h00, 8'h00, 1'b1);
      cyc(20);
      expect_st("basic_frozen", 8'h04, 8'h08, 8'h00, 8'h00, 8'h00, 1'b1);

      // Async reset mid-EXEC of INC R0
      p = '{8'h45, 8'hD0, 8'hC0};
      load_reset(p, 1'b1);
      cyc(2);
      expect_st("pre_inc", 8'h01, 8'h05, 8'h00, 8'h00, 8'h00, 1'b0);
      cyc(1);
      #2 rst_n = 1'b0;
      #1 expect_st("async_reset", 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      expect_st("post_reset_fetch", 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
      cyc(2);
      expect_st("post_reset_ldi", 8'h01, 8'h05, 8'h00, 8'h00, 8'h00, 1'b0);

      // Branch loop
      p = '{8'h63, 8'hE8, 8'hAF, 8'hC0};
      load_reset(p, 1'b1);
      br_seq = '{8'h00, 8'h01, 8'h02, 8'h01, 8'h02, 8'h01, 8'h02, 8'h03};
      for (int i = 0; i < 8; i++) begin
         total++;
         if (instr_addr !== br_seq[i]) begin
            bad++;
            $display("FAIL branch_pc_%0d: got %h, want %h", i, instr_addr, br_seq[i]);
         end
         cyc(2);
      end
      expect_st("branch_final", 8'h03, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1);

      // Run gating
      p = '{8'h45, 8'h53, 8'h01, 8'h15, 8'hC0};
      load_reset(p, 1'b1);
      cyc(2);
      run = 1'b0;
      cyc(7);
      expect_st("run_hold_fetch", 8'h01, 8'h05, 8'h00, 8'h00, 8'h00, 1'b0);
      run = 1'b1;
      cyc(1);
      run = 1'b0;
      cyc(6);
      expect_st("run_drop_exec", 8'h02, 8'h05, 8'h03, 8'h00, 8'h00, 1'b0);

      // PC wrap from FF (second instance) and 8-bit register wrap
      p = '{8'h70, 8'hEC, 8'h4F, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hC0};
      load_reset(p, 1'b0);
      rom[255] = 8'hFF;
      expect_b("pc_reset_ff", 8'hFF);
      run_b = 1'b1;
      cyc(2);
      run_b = 1'b0;
      expect_b("pc_wrap", 8'h00);
      run = 1'b1;
      cyc(4);
      expect_st("dec_wrap", 8'h02, 8'h00, 8'h00, 8'h00, 8'hFF, 1'b0);
      cyc(10);
      expect_st("add_x4", 8'h07, 8'hF0, 8'h00, 8'h00, 8'hFF, 1'b0);
      cyc(2);
      expect_st("add_mod", 8'h08, 8'hE0, 8'h00, 8'h00, 8'hFF, 1'b0);

      // Logic ops, aliasing, untaken branch
      p = '{8'h5C, 8'h6A, 8'h26, 8'h39, 8'h0A, 8'hB2, 8'hC0};
      load_reset(p, 1'b1);
      cyc(6);
      expect_st("and", 8'h03, 8'h00, 8'h08, 8'h0A, 8'h00, 1'b0);
      cyc(2);
      expect_st("or", 8'h04, 8'h00, 8'h08, 8'h0A, 8'h00, 1'b0);
      cyc(2);
      expect_st("add_alias", 8'h05, 8'h00, 8'h08, 8'h14, 8'h00, 1'b0);
      cyc(2);
      expect_st("bnz_untaken", 8'h06, 8'h00, 8'h08, 8'h14, 8'h00, 1'b0);
      cyc(2);
      expect_st("halt_after_bnz", 8'h06, 8'h00, 8'h08, 8'h14, 8'h00, 1'b1);

      #2;
      if (exp_q.size() != 0) begin
         total++;
         bad++;
         $display("FAIL scoreboard_drain: got %0d pending, want 0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
